// File: rtl/data_mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment check, store lane
// shaping and a req/ack handshake that stalls the pipeline while in flight.
module data_mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [1:0]  BHW,
  input  logic        ExtendSign,
  output logic        Stall,
  output logic [31:0] LoadWord,
  output logic [1:0]  LoadBHW,
  output logic [1:0]  LoadLower2,
  output logic        LoadExtendSign,
  output logic        LoadValid,
  output logic        AccessErr,
  output logic        BusErr,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  localparam int unsigned CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic          req;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          misalign;
  logic          illegal;
  logic          accept;
  logic          ack_hit;
  logic          to_hit;

  logic [31:0]   lane_wdata;
  logic [3:0]    lane_be;
  logic [1:0]    lane_low;

  logic          r_we;
  logic [29:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [1:0]    r_bhw;
  logic [1:0]    r_low;
  logic          r_es;

  assign req = Read | Write;

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    misalign = 1'b0;
    unique case (BHW)
      2'd0: is_byte = 1'b1;
      2'd1: begin
        is_half  = 1'b1;
        misalign = Addr[0];
      end
      2'd2: begin
        is_word  = 1'b1;
        misalign = |Addr[1:0];
      end
      default: ;
    endcase
  end

  assign illegal = ~(is_byte | is_half | is_word)
                 | misalign
                 | (Read & Write);
  assign accept  = (state == IDLE) & req & ~illegal;

  // Loads always fetch the full word; lane selection happens downstream.
  always_comb begin
    lane_wdata = StoreData;
    lane_be    = 4'b1111;
    lane_low   = 2'b00;
    unique case (1'b1)
      is_byte: begin
        lane_wdata = {4{StoreData[7:0]}};
        lane_be    = 4'b0001 << Addr[1:0];
        lane_low   = Addr[1:0];
      end
      is_half: begin
        lane_wdata = {2{StoreData[15:0]}};
        lane_be    = Addr[1] ? 4'b1100 : 4'b0011;
        lane_low   = {1'b0, Addr[1]};
      end
      default: ;
    endcase
    if (!Write) begin
      lane_be = 4'b1111;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CW'(1);
        if (MemAck) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (TO_EN && (cnt_nxt == TO_V)) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_be           <= '0;
      r_bhw          <= '0;
      r_low          <= '0;
      r_es           <= 1'b0;
      LoadWord       <= '0;
      LoadBHW        <= '0;
      LoadLower2     <= '0;
      LoadExtendSign <= 1'b0;
      LoadValid      <= 1'b0;
      AccessErr      <= 1'b0;
      BusErr         <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      AccessErr <= (state == IDLE) & req & illegal;
      BusErr    <= to_hit;
      LoadValid <= ack_hit & ~r_we;
      if (accept) begin
        r_we    <= Write;
        r_addr  <= Addr[31:2];
        r_wdata <= lane_wdata;
        r_be    <= lane_be;
        r_bhw   <= BHW;
        r_low   <= lane_low;
        r_es    <= ExtendSign;
      end
      if (ack_hit && !r_we) begin
        LoadWord       <= MemRData;
        LoadBHW        <= r_bhw;
        LoadLower2     <= r_low;
        LoadExtendSign <= r_es;
      end
    end
  end

  // Reset gates the accept term so Stall drops the instant reset asserts.
  assign MemReq   = (state == BUSY);
  assign Stall    = MemReq | (accept & Reset_n);
  assign MemWE    = r_we;
  assign MemAddr  = {r_addr, 2'b00};
  assign MemWData = r_wdata;
  assign MemBE    = r_be;

endmodule
